// File: rtl/wb_sram_slave_pkg.sv
// Shared widths and FSM encoding for the Wishbone SRAM slave.
package wb_sram_slave_pkg;

  localparam int CORE_ADDR_WIDTH = 32;
  localparam int CORE_DATA_WIDTH = 32;
  localparam int CORE_BE_WIDTH   = 4;

  // Wait-state counter holds 0..15.
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_sram_slave_if.sv
// Wishbone B4 pipelined bus between the L1 memory access unit and the SRAM slave.
interface wb_sram_slave_if;
  import wb_sram_slave_pkg::*;

  logic                       wb_cyc_i;
  logic                       wb_stb_i;
  logic                       wb_we_i;
  logic [CORE_ADDR_WIDTH-1:0] wb_adr_i;
  logic [CORE_DATA_WIDTH-1:0] wb_dat_i;
  logic [CORE_BE_WIDTH-1:0]   wb_sel_i;
  logic [CORE_DATA_WIDTH-1:0] wb_dat_o;
  logic                       wb_ack_o;
  logic                       wb_err_o;
  logic                       wb_stall_o;

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

endinterface

// File: rtl/wb_sram_slave_array.sv
// Single-port synchronous SRAM with byte enables; no reset so it maps to block RAM.
module wb_sram_array #(
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**MEM_AW];
  logic [31:0] r_rdata;

  // Byte-masked write and registered read (old data on a same-cycle write).
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B4 pipelined slave in front of an on-chip SRAM, with optional wait states
// and error termination for addresses outside the memory window.
module wb_sram_slave
  import wb_sram_slave_pkg::*;
#(
  parameter int          MEM_AW      = 14,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input logic            clk,
  input logic            rst_n,
  wb_sram_slave_if.slave wb
);

  localparam logic [WAIT_CNT_W-1:0] WS = WAIT_CNT_W'(WAIT_STATES);

  wb_state_e                  r_state, w_state_nxt;
  logic [WAIT_CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic                       r_we, r_err;
  logic [MEM_AW-1:0]          r_addr;
  logic [CORE_DATA_WIDTH-1:0] r_wdat;
  logic [CORE_BE_WIDTH-1:0]   r_sel;

  logic                       w_accept, w_in_range, w_resp;
  logic [CORE_ADDR_WIDTH-1:0] w_off;
  logic [MEM_AW-1:0]          w_bus_addr;
  logic                       w_mem_en, w_mem_we;
  logic [MEM_AW-1:0]          w_mem_addr;
  logic [3:0]                 w_mem_be;
  logic [31:0]                w_mem_wdat, w_mem_rdat;
  logic                       w_unused;

  // Window check on the offset from the base; byte lane bits carry no meaning.
  assign w_off      = wb.wb_adr_i - BASE_ADDR;
  assign w_in_range = (w_off >> (MEM_AW + 2)) == '0;
  assign w_bus_addr = w_off[MEM_AW+1:2];
  assign w_unused   = &{1'b0, w_off[1:0]};
  assign w_accept   = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_stall_o;

  // State, wait counter and response-type control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we  <= wb.wb_we_i;
        r_err <= ~w_in_range;
      end
    end
  end

  // Request payload captured on acceptance for the delayed SRAM access.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr <= w_bus_addr;
      r_wdat <= wb.wb_dat_i;
      r_sel  <= wb.wb_sel_i;
    end
  end

  // Next state, counter and SRAM port selection; a zero-wait access goes straight
  // from the bus, otherwise the registered request is replayed in the last wait cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mem_en    = 1'b0;
    w_mem_we    = wb.wb_we_i;
    w_mem_addr  = w_bus_addr;
    w_mem_be    = wb.wb_sel_i;
    w_mem_wdat  = wb.wb_dat_i;
    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_accept) begin
          if (WS == '0) begin
            w_state_nxt = ST_RESP;
            w_mem_en    = w_in_range;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = WS;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        w_mem_we   = r_we;
        w_mem_addr = r_addr;
        w_mem_be   = r_sel;
        w_mem_wdat = r_wdat;
        w_cnt_nxt  = r_cnt - 1'b1;
        if (!wb.wb_cyc_i) begin
          // Master abandoned the cycle: drop the request before it touches the SRAM.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == WAIT_CNT_W'(1)) begin
          w_state_nxt = ST_RESP;
          w_mem_en    = ~r_err;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  wb_sram_array #(.MEM_AW(MEM_AW)) u_array (
    .clk     (clk),
    .i_en    (w_mem_en),
    .i_we    (w_mem_we),
    .i_be    (w_mem_be),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdat),
    .o_rdata (w_mem_rdat)
  );

  assign w_resp        = (r_state == ST_RESP);
  assign wb.wb_ack_o   = w_resp & ~r_err;
  assign wb.wb_err_o   = w_resp & r_err;
  assign wb.wb_stall_o = (r_state == ST_WAIT);
  assign wb.wb_dat_o   = (w_resp & ~r_err & ~r_we) ? w_mem_rdat : '0;

endmodule

// File: tb/tb_wb_sram_slave.sv
// Scoreboard bench for wb_sram_slave: one instance with no wait states, one with three.
module tb_wb_sram_slave;
  import wb_sram_slave_pkg::*;

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] exp_dat;
    int          idx;
    logic [31:0] wdat;
    logic [3:0]  sel;
    int          t;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_sram_slave_if bus0 ();
  wb_sram_slave_if bus3 ();

  wb_sram_slave #(.MEM_AW(14), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wb(bus0.slave));
  wb_sram_slave #(.MEM_AW(14), .BASE_ADDR(32'h0), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .wb(bus3.slave));

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc_cnt = 0;
  bit          mon_en = 1'b0;
  ent_t        q0[$];
  ent_t        q3[$];
  logic [31:0] mdl0[int];
  logic [31:0] mdl3[int];
  int          acc_cnt[2];
  int          last_acc[2];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc_cnt);
    end
  endtask

  function automatic int wsof(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q3.size();
  endfunction

  function automatic ent_t q_head(input int d);
    return (d == 0) ? q0[0] : q3[0];
  endfunction

  task automatic q_pop(input int d);
    if (d == 0) void'(q0.pop_front()); else void'(q3.pop_front());
  endtask

  task automatic q_push(input int d, input ent_t e);
    if (d == 0) q0.push_back(e); else q3.push_back(e);
  endtask

  function automatic logic [31:0] mdl_rd(input int d, input int idx);
    if (d == 0) return mdl0.exists(idx) ? mdl0[idx] : 32'h0;
    return mdl3.exists(idx) ? mdl3[idx] : 32'h0;
  endfunction

  task automatic mdl_wr(input int d, input int idx, input logic [31:0] wdat, input logic [3:0] sel);
    logic [31:0] v = mdl_rd(d, idx);
    for (int b = 0; b < 4; b++) if (sel[b]) v[8*b +: 8] = wdat[8*b +: 8];
    if (d == 0) mdl0[idx] = v; else mdl3[idx] = v;
  endtask

  // One cycle of scoreboard activity for one instance, sampled on the falling edge.
  task automatic step(input int d, input logic cyc, input logic stb, input logic we,
                      input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel,
                      input logic ack, input logic err, input logic stall, input logic [31:0] rdat);
    string p = (d == 0) ? "ws0" : "ws3";
    int    ws = wsof(d);
    logic  exp_stall = 1'b0;
    logic  due = 1'b0;
    ent_t  e;
    if (q_size(d) != 0) begin
      e = q_head(d);
      exp_stall = (cyc_cnt - e.t >= 1) && (cyc_cnt - e.t <= ws);
      due = (cyc_cnt - e.t == ws + 1);
    end
    chk({p, "_stall"}, stall, exp_stall);
    if (ack || err || due) begin
      if (q_size(d) == 0) begin
        chk({p, "_spurious_resp"}, {ack, err}, 2'b00);
      end else begin
        chk({p, "_ack"}, ack, !e.err);
        chk({p, "_err"}, err, e.err);
        chk({p, "_dat"}, rdat, e.exp_dat);
        chk({p, "_latency"}, cyc_cnt - e.t, ws + 1);
        if (!e.err && e.we) mdl_wr(d, e.idx, e.wdat, e.sel);
        q_pop(d);
      end
    end else if (q_size(d) != 0 && !cyc) begin
      q_pop(d);
    end
    if (cyc && stb && !exp_stall) begin
      e.t       = cyc_cnt;
      e.we      = we;
      e.err     = !(adr < 32'h0001_0000);
      e.idx     = int'(adr >> 2);
      e.wdat    = wdat;
      e.sel     = sel;
      e.exp_dat = (e.err || we) ? 32'h0 : mdl_rd(d, e.idx);
      q_push(d, e);
      acc_cnt[d]++;
      last_acc[d] = cyc_cnt;
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      step(0, bus0.wb_cyc_i, bus0.wb_stb_i, bus0.wb_we_i, bus0.wb_adr_i, bus0.wb_dat_i,
           bus0.wb_sel_i, bus0.wb_ack_o, bus0.wb_err_o, bus0.wb_stall_o, bus0.wb_dat_o);
      step(1, bus3.wb_cyc_i, bus3.wb_stb_i, bus3.wb_we_i, bus3.wb_adr_i, bus3.wb_dat_i,
           bus3.wb_sel_i, bus3.wb_ack_o, bus3.wb_err_o, bus3.wb_stall_o, bus3.wb_dat_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input int d, input logic cyc, input logic stb, input logic we,
                     input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    if (d == 0) begin
      bus0.wb_cyc_i = cyc; bus0.wb_stb_i = stb; bus0.wb_we_i = we;
      bus0.wb_adr_i = adr; bus0.wb_dat_i = dat; bus0.wb_sel_i = sel;
    end else begin
      bus3.wb_cyc_i = cyc; bus3.wb_stb_i = stb; bus3.wb_we_i = we;
      bus3.wb_adr_i = adr; bus3.wb_dat_i = dat; bus3.wb_sel_i = sel;
    end
  endtask

  // Present one request and hold stb until it is accepted (bounded).
  task automatic req(input int d, input logic we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    int a0 = acc_cnt[d];
    bit ok = 1'b0;
    drv(d, 1'b1, 1'b1, we, adr, dat, sel);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (acc_cnt[d] != a0) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", ok, 1'b1);
    drv(d, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  // Keep cyc high until every outstanding response has been seen, then release the bus.
  task automatic drain(input int d);
    bit ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (q_size(d) == 0) begin ok = 1'b1; break; end
      tick();
    end
    chk("drain_timeout", ok, 1'b1);
    drv(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
  endtask

  task automatic single(input int d, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel);
    req(d, we, adr, dat, sel);
    drain(d);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int a0, ta, tb;
    drv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    acc_cnt[0] = 0; acc_cnt[1] = 0;
    last_acc[0] = 0; last_acc[1] = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_ack0", bus0.wb_ack_o, 1'b0);
    chk("rst_err0", bus0.wb_err_o, 1'b0);
    chk("rst_stall0", bus0.wb_stall_o, 1'b0);
    chk("rst_dat0", bus0.wb_dat_o, 32'h0);
    chk("rst_ack3", bus3.wb_ack_o, 1'b0);
    chk("rst_err3", bus3.wb_err_o, 1'b0);
    chk("rst_stall3", bus3.wb_stall_o, 1'b0);
    chk("rst_dat3", bus3.wb_dat_o, 32'h0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    for (int d = 0; d < 2; d++) begin
      // Full write then read back.
      single(d, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
      single(d, 1'b0, 32'h10, 32'h0, 4'h0);
      // Partial write merges into the existing word.
      single(d, 1'b1, 32'h20, 32'h1122_3344, 4'hF);
      single(d, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101);
      single(d, 1'b0, 32'h20, 32'h0, 4'h0);
      chk("partial_model", mdl_rd(d, 8), 32'h11BB_33DD);
      // Seed words 0..3.
      for (int i = 0; i < 4; i++) single(d, 1'b1, 32'(4 * i), 32'hC0DE_0000 + 32'(i), 4'hF);
      // Out-of-range read and write, then in-range read unaffected by the write.
      single(d, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
      single(d, 1'b1, 32'h0001_0010, 32'h0BAD_0BAD, 4'hF);
      single(d, 1'b0, 32'h10, 32'h0, 4'hF);
    end

    // Four pipelined reads with no wait states: no stall, consecutive acks.
    a0 = acc_cnt[0];
    for (int i = 0; i < 4; i++) begin
      drv(0, 1'b1, 1'b1, 1'b0, 32'(4 * i), 32'h0, 4'h0);
      tick();
    end
    drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drain(0);
    chk("b2b_accepts", acc_cnt[0] - a0, 4);

    // Write then read the same word in consecutive accepts.
    drv(0, 1'b1, 1'b1, 1'b1, 32'h44, 32'h7777_8888, 4'hF);
    tick();
    drv(0, 1'b1, 1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    tick();
    drv(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drain(0);

    // Three wait states: second request held through the stall is taken in the ack cycle.
    drv(1, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
    tick();
    ta = last_acc[1];
    a0 = acc_cnt[1];
    req(1, 1'b0, 32'h20, 32'h0, 4'h0);
    tb = last_acc[1];
    chk("ws3_accept_gap", tb - ta, 4);
    chk("ws3_accepts", acc_cnt[1] - a0, 1);
    drain(1);

    // Abort: drop cyc one wait cycle into a write; the old word must survive.
    single(1, 1'b1, 32'h30, 32'h5A5A_0030, 4'hF);
    drv(1, 1'b1, 1'b1, 1'b1, 32'h30, 32'hFFFF_FFFF, 4'hF);
    tick();
    drv(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    drv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    repeat (6) tick();
    single(1, 1'b0, 32'h30, 32'h0, 4'h0);

    // Random byte-masked traffic over a small seeded window.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) single(d, 1'b1, 32'h400 + 32'(4 * i), $urandom, 4'hF);
      for (int i = 0; i < 16; i++) begin
        single(d, 1'($urandom_range(0, 1)), 32'h400 + 32'(4 * $urandom_range(0, 7)),
               $urandom, 4'($urandom_range(0, 15)));
      end
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
